cpuregs_arb: RTL and testbench

CPUREGS_ARB -- requirements
Module: cpuregs_arb

---
 rtl/pdp2011_pkg.sv | 21 ++
 rtl/cpuregs_arb.sv | 103 ++++++++++
 tb/tb_cpuregs_arb.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdp2011_pkg.sv
// Shared PDP-11 register-file definitions: arbiter state encoding, address fields, defaults.
package pdp2011_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } arb_state_t;

    // Register address = {mode[1:0], set, reg[2:0]}
    localparam logic [2:0] REG_SP      = 3'd6;
    localparam logic [1:0] MODE_KERNEL = 2'b00;
    localparam logic [1:0] MODE_SUPER  = 2'b01;
    localparam logic [1:0] MODE_USER   = 2'b11;

    localparam int unsigned STARVE_LIMIT_DEF = 8;

    function automatic logic [1:0] addr_mode(input logic [5:0] addr);
        return addr[5:4];
    endfunction

endpackage

// File: rtl/cpuregs_arb.sv
// Arbitrates the CPU and the console/debug port onto one register-file port.
// CPUREGS_ARB_FORCE_EN enables the starvation counter and forced (CPU-stalling) debug grants.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | CPU owns the register file; debug granted when CPU idle or forced
// ST_ACK  | debug access done, dbg_ack high until dbg_req drops
module cpuregs_arb
    import pdp2011_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [5:0]  cpu_raddr,
    input  logic [5:0]  cpu_waddr,
    input  logic [15:0] cpu_d,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [5:0]  dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,
    output logic [5:0]  rf_raddr,
    output logic [5:0]  rf_waddr,
    output logic [15:0] rf_d,
    output logic        rf_we,
    input  logic [15:0] rf_o
);

    arb_state_t state, state_nxt;
    logic       grant;
    logic       forced;

    assign grant = (state == ST_IDLE) && dbg_req && (!cpu_en || forced);

`ifdef CPUREGS_ARB_FORCE_EN
    logic [7:0] starve_cnt;

    assign forced = (starve_cnt == 8'(STARVE_LIMIT));

    // Counts only while a pending request is being denied; saturates at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 8'd0;
        end else if (grant || !dbg_req) begin
            starve_cnt <= 8'd0;
        end else if ((state == ST_IDLE) && cpu_en && !forced) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    logic [7:0] unused_starve_limit;

    assign forced              = 1'b0;
    assign unused_starve_limit = 8'(STARVE_LIMIT);
`endif

    always_comb begin
        state_nxt = state;
        rf_raddr  = cpu_raddr;
        rf_waddr  = cpu_waddr;
        rf_d      = cpu_d;
        rf_we     = cpu_en && cpu_we;
        cpu_stall = 1'b0;
        dbg_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    rf_raddr  = dbg_addr;
                    rf_waddr  = dbg_addr;
                    rf_d      = dbg_wdata;
                    rf_we     = dbg_we;
                    cpu_stall = forced && cpu_en;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                dbg_ack = 1'b1;
                if (!dbg_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            dbg_rdata <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (grant && !dbg_we) begin
                dbg_rdata <= rf_o;
            end
        end
    end

endmodule

// File: tb/tb_cpuregs_arb.sv
// Directed bench for cpuregs_arb with a behavioural 64-entry register file behind the rf port.
module tb_cpuregs_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_en, cpu_we;
    logic [5:0]  cpu_raddr, cpu_waddr;
    logic [15:0] cpu_d;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [5:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic [5:0]  rf_raddr, rf_waddr;
    logic [15:0] rf_d;
    logic        rf_we;
    logic [15:0] rf_o;

    logic [15:0] regs [64];
    logic        tb_init;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    cpuregs_arb #(.STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_en    (cpu_en),
        .cpu_we    (cpu_we),
        .cpu_raddr (cpu_raddr),
        .cpu_waddr (cpu_waddr),
        .cpu_d     (cpu_d),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .rf_raddr  (rf_raddr),
        .rf_waddr  (rf_waddr),
        .rf_d      (rf_d),
        .rf_we     (rf_we),
        .rf_o      (rf_o)
    );

    // Register file is not reset, so writes survive an arbiter reset.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int k = 0; k < 64; k++) regs[k] <= 16'h0000;
        end else if (rf_we) begin
            regs[rf_waddr] <= rf_d;
        end
    end
    assign rf_o = regs[rf_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        tb_init   = 1'b1;
        cpu_en    = 1'b0;
        cpu_we    = 1'b0;
        cpu_raddr = 6'o00;
        cpu_waddr = 6'o00;
        cpu_d     = 16'h0000;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = 6'o00;
        dbg_wdata = 16'h0000;
        #2;
        check("rst_ack",   dbg_ack,   0);
        check("rst_rdata", dbg_rdata, 16'h0000);
        check("rst_stall", cpu_stall, 0);
        repeat (3) @(posedge clk);
        tb_init = 1'b0;
        #1;
        reset_n = 1'b1;
        step();

        // Debug write to SP while the CPU is idle
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'o06; dbg_wdata = 16'h1234;
        #1;
        check("wr_grant_we",   rf_we,    1);
        check("wr_grant_addr", rf_waddr, 6'o06);
        check("wr_grant_d",    rf_d,     16'h1234);
        check("wr_grant_ack",  dbg_ack,  0);
        step();
        check("wr_ack",     dbg_ack, 1);
        check("wr_ack_we0", rf_we,   0);
        dbg_req = 0;
        #1;
        check("wr_ack_hold", dbg_ack, 1);
        step();
        check("wr_idle",   dbg_ack,  0);
        check("wr_commit", regs[6],  16'h1234);

        // Debug read back
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'o06;
        #1;
        check("rd_grant_addr", rf_raddr, 6'o06);
        check("rd_grant_we",   rf_we,    0);
        step();
        check("rd_ack",   dbg_ack,   1);
        check("rd_rdata", dbg_rdata, 16'h1234);
        dbg_req = 0;
        step();

        // CPU busy writing user-mode reg; debug read waits for an idle CPU cycle
        cpu_en = 1; cpu_we = 1; cpu_waddr = 6'o60; cpu_d = 16'hBEEF;
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'o60;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cpu_wr_we",    rf_we,     1);
            check("cpu_wr_addr",  rf_waddr,  6'o60);
            check("cpu_wr_d",     rf_d,      16'hBEEF);
            check("cpu_busy_ack", dbg_ack,   0);
            check("cpu_busy_stl", cpu_stall, 0);
            step();
        end
        cpu_en = 0; cpu_we = 0;
        #1;
        check("late_grant_addr", rf_raddr, 6'o60);
        step();
        check("late_ack",   dbg_ack,   1);
        check("late_rdata", dbg_rdata, 16'hBEEF);

        // Hold request 5 cycles; a CPU write meanwhile must not be re-read
        for (int i = 0; i < 5; i++) begin
            cpu_en = (i == 1); cpu_we = (i == 1); cpu_waddr = 6'o60; cpu_d = 16'h5555;
            cpu_raddr = 6'o13;
            #1;
            check("hold_ack",   dbg_ack,  1);
            check("hold_raddr", rf_raddr, 6'o13);
            check("hold_we",    rf_we,    (i == 1));
            step();
        end
        cpu_en = 0; cpu_we = 0;
        check("hold_rdata", dbg_rdata, 16'hBEEF);
        check("hold_cpuwr", regs[6'o60], 16'h5555);
        dbg_req = 0;
        #1;
        check("drop_ack_still", dbg_ack, 1);
        step();
        check("drop_idle", dbg_ack, 0);

        // Debug write leaves dbg_rdata untouched
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'o17; dbg_wdata = 16'hA5A5;
        step();
        check("wr2_ack",   dbg_ack,   1);
        check("wr2_rdata", dbg_rdata, 16'hBEEF);
        dbg_req = 0;
        step();
        check("wr2_commit", regs[6'o17], 16'hA5A5);

        // Abort: request withdrawn before grant
        cpu_en = 1; cpu_we = 0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'o21; dbg_wdata = 16'h7777;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("abort_we_busy", rf_we, 0);
            step();
        end
        dbg_req = 0; cpu_en = 0;
        #1;
        check("abort_we", rf_we, 0);
        step();
        check("abort_ack", dbg_ack, 0);
        step();
        check("abort_ack2", dbg_ack, 0);
        check("abort_reg",  regs[6'o21], 16'h0000);

        // CPU busy every cycle with a pending debug read
        cpu_en = 1; cpu_we = 0; cpu_raddr = 6'o00;
        dbg_req = 1; dbg_we = 0; dbg_addr = 6'o06;
        for (int i = 1; i <= 12; i++) begin
            #1;
`ifdef CPUREGS_ARB_FORCE_EN
            check("starve_stall", cpu_stall, (i == 9));
            check("starve_ack",   dbg_ack,   (i >= 10));
`else
            check("starve_stall", cpu_stall, 0);
            check("starve_ack",   dbg_ack,   0);
`endif
            step();
        end
`ifdef CPUREGS_ARB_FORCE_EN
        check("starve_rdata", dbg_rdata, 16'h1234);
`else
        check("starve_rdata", dbg_rdata, 16'hBEEF);
`endif
        dbg_req = 0; cpu_en = 0;
        step();
        step();

        // Reset in the middle of ACK after a granted write
        dbg_req = 1; dbg_we = 1; dbg_addr = 6'o22; dbg_wdata = 16'h4242;
        step();
        check("rstack_pre", dbg_ack, 1);
        reset_n = 0;
        #1;
        check("rstack_ack",   dbg_ack,     0);
        check("rstack_rdata", dbg_rdata,   16'h0000);
        check("rstack_reg",   regs[6'o22], 16'h4242);
        dbg_req = 0;
        step();
        reset_n = 1;
        step();
        check("post_rst_ack", dbg_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
